wishbone_master_arbiter: RTL and testbench
==========================================

// Module: wishbone_master_arbiter
// PURPOSE
//   N-to-1 Wishbone Classic arbiter: shares one slave-side bus (the peripheral splitter's master port) among
//   NUM_MASTERS requesters. Round-robin grant held for a whole CYC. Registered grant, combinational data path.
// PARAMETERS
//   NUM_MASTERS    2     number of requesting masters (>=2)
//   ADDR_WIDTH     32    Wishbone address width
//   DATA_WIDTH     32    Wishbone data width
//   SEL_WIDTH      DATA_WIDTH/8  byte-select width
//   TIMEOUT_CYCLES 255   watchdog limit, cycles of STB without ACK/ERR (WB_ARB_TIMEOUT_EN only)
// PORTS
//   wb_clk_i    in   1                        bus clock, single clock domain
//   wb_rst_i    in   1                        synchronous reset, active-high
//   m_wb_cyc_i  in   NUM_MASTERS              per-master CYC (bus request)
//   m_wb_stb_i  in   NUM_MASTERS              per-master STB
//   m_wb_we_i   in   NUM_MASTERS              per-master WE
//   m_wb_sel_i  in   NUM_MASTERS*SEL_WIDTH    packed byte selects
//   m_wb_adr_i  in   NUM_MASTERS*ADDR_WIDTH   packed addresses
//   m_wb_dat_i  in   NUM_MASTERS*DATA_WIDTH   packed write data
//   m_wb_dat_o  out  DATA_WIDTH               read data, broadcast to all masters
//   m_wb_ack_o  out  NUM_MASTERS              ACK, only granted master
//   m_wb_err_o  out  NUM_MASTERS              ERR, only granted master
//   m_wb_gnt_o  out  NUM_MASTERS              one-hot current grant (status)
//   s_wb_cyc_o/s_wb_stb_o/s_wb_we_o  out 1; s_wb_sel_o out SEL_WIDTH; s_wb_adr_o out ADDR_WIDTH;
//   s_wb_dat_o  out  DATA_WIDTH; s_wb_dat_i in DATA_WIDTH; s_wb_ack_i in 1; s_wb_err_i in 1   shared slave bus
// BEHAVIOUR
//   Reset (sync, wb_rst_i=1 at edge): state=IDLE, gnt=0, last_idx=NUM_MASTERS-1 (master 0 wins first);
//   all s_wb_cyc/stb, m_wb_ack/err, m_wb_gnt = 0. Reset mid-transfer drops slave CYC/STB on next edge.
//   States: IDLE -> GRANT when any m_wb_cyc_i; GRANT -> IDLE when granted master's m_wb_cyc_i=0.
//   IDLE: winner = first requester scanning from last_idx+1 upward, wrapping modulo NUM_MASTERS;
//     grant registered -> slave sees CYC one cycle after request (latency 1). No slave outputs in IDLE.
//   GRANT: slave cyc/stb/we/sel/adr/dat = granted master's signals (combinational);
//     m_wb_ack_o/err_o[g] = s_wb_ack_i/s_wb_err_i for g=granted, 0 for others; gnt held until CYC drops,
//     ignoring other requests (no preemption). On release last_idx<=granted index; one IDLE cycle
//     always separates consecutive ownerships.
//   Simultaneous requests: strict round-robin order; a master re-requesting loses to any waiting master.
//   m_wb_dat_o = s_wb_dat_i always. s_wb_cyc_o never asserted without a registered grant.
// CONFIGURATION
//   WB_ARB_TIMEOUT_EN defined: counter (width $clog2(TIMEOUT_CYCLES+1)) increments each GRANT cycle with
//     s_wb_stb_o=1 and no ACK/ERR; clears on ACK, ERR, STB low or IDLE. On reaching TIMEOUT_CYCLES:
//     granted master gets 1-cycle m_wb_err_o, s_wb_stb_o forced 0 that cycle, counter clears; grant kept.
//   Not defined: no counter; a stalled slave holds the bus indefinitely.
// STRUCTURE
//   Package wb_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_GRANT}; helper function onehot index.
//   Sub-module wb_arb_rr_picker (req, last_idx -> winner_idx, winner_valid), purely combinational.
//   Top holds FSM, grant/last_idx registers, muxes, optional watchdog.
// TESTING
//   1 NUM_MASTERS=2; reset, m0 cyc/stb read adr 0x0001_0004, slave acks 0x1234 -> gnt=01 one cycle later,
//     m_wb_ack_o=01, m_wb_dat_o=0x1234; m1 sees ack 0.
//   2 m0,m1 request same cycle after reset -> m0 granted; m0 drops CYC -> IDLE 1 cycle -> m1 granted.
//   3 m1 holds CYC over 3 back-to-back STB/ACK writes while m0 requests -> gnt stays 10 until m1 CYC=0.
//   4 NUM_MASTERS=3 all requesting continuously, 1-beat transfers -> grant order 0,1,2,0,1,2.
//   5 wb_rst_i asserted during m0 GRANT with STB high -> next edge s_wb_cyc_o=0, gnt=0, state IDLE.
//   6 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m0 err pulse at 8th stalled cycle,
//     s_wb_stb_o=0 that cycle; without macro, no err after 100 cycles.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone N-to-1 master arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_MASTERS = 32;

    function automatic int onehot_to_idx(input logic [MAX_MASTERS-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker: first requester after last_idx, wrapping.
module wb_arb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_idx,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   winner_valid
);

    // Scan offsets from farthest to nearest so the nearest requester overwrites;
    // offset NUM_MASTERS is the previous owner itself, i.e. lowest priority.
    always_comb begin
        winner_idx   = '0;
        winner_valid = 1'b0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            int cand;
            cand = int'(last_idx) + off;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (req[IDX_W'(cand)]) begin
                winner_idx   = IDX_W'(cand);
                winner_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_master_arbiter.sv
// Wishbone Classic N-to-1 arbiter: registered round-robin grant held for a whole CYC.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_we_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i,
    output logic [DATA_WIDTH-1:0]             m_wb_dat_o,
    output logic [NUM_MASTERS-1:0]            m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]            m_wb_err_o,
    output logic [NUM_MASTERS-1:0]            m_wb_gnt_o,
    output logic                              s_wb_cyc_o,
    output logic                              s_wb_stb_o,
    output logic                              s_wb_we_o,
    output logic [SEL_WIDTH-1:0]              s_wb_sel_o,
    output logic [ADDR_WIDTH-1:0]             s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]             s_wb_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_wb_dat_i,
    input  logic                              s_wb_ack_i,
    input  logic                              s_wb_err_i
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]       last_idx_q, last_idx_d;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   granted;
    logic                   timeout_fire;

    assign gnt_idx = IDX_W'(onehot_to_idx(MAX_MASTERS'(gnt_q)));
    assign granted = (state_q == ARB_GRANT);

    wb_arb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req          (m_wb_cyc_i),
        .last_idx     (last_idx_q),
        .winner_idx   (pick_idx),
        .winner_valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_idx_d = last_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    gnt_d   = NUM_MASTERS'(1) << pick_idx;
                end
            end
            ARB_GRANT: begin
                if (!m_wb_cyc_i[gnt_idx]) begin
                    state_d    = ARB_IDLE;
                    gnt_d      = '0;
                    last_idx_d = gnt_idx;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Slave bus follows the registered owner only; nothing leaks out while idle.
    always_comb begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_sel_o = '0;
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        m_wb_ack_o = '0;
        m_wb_err_o = '0;
        if (granted) begin
            s_wb_cyc_o          = m_wb_cyc_i[gnt_idx];
            s_wb_stb_o          = m_wb_stb_i[gnt_idx] & ~timeout_fire;
            s_wb_we_o           = m_wb_we_i[gnt_idx];
            s_wb_sel_o          = m_wb_sel_i[gnt_idx*SEL_WIDTH +: SEL_WIDTH];
            s_wb_adr_o          = m_wb_adr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_wb_dat_o          = m_wb_dat_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            m_wb_ack_o[gnt_idx] = s_wb_ack_i;
            m_wb_err_o[gnt_idx] = s_wb_err_i | timeout_fire;
        end
    end

    assign m_wb_dat_o = s_wb_dat_i;
    assign m_wb_gnt_o = gnt_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             stalled;

    // wdog_q holds the stalled cycles already seen, so the limit-th one fires.
    assign stalled      = granted & m_wb_stb_i[gnt_idx] & ~s_wb_ack_i & ~s_wb_err_i;
    assign timeout_fire = stalled & (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign wdog_d       = (stalled && !timeout_fire) ? wdog_q + CNT_W'(1) : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            last_idx_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_idx_q <= last_idx_d;
        end
    end

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Self-checking bench for wishbone_master_arbiter: directed scenarios plus random traffic
// against a behavioural round-robin model. Define WB_ARB_TIMEOUT_EN to cover the watchdog.
module tb_wishbone_master_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_cyc = '0;
    logic [NM-1:0]     m_stb = '0;
    logic [NM-1:0]     m_we = '0;
    logic [NM*SW-1:0]  m_sel = '0;
    logic [NM*AW-1:0]  m_adr = '0;
    logic [NM*DW-1:0]  m_dat = '0;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [NM-1:0]     m_gnt_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [SW-1:0]     s_sel_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW-1:0]     s_dat_i = '0;
    logic              s_ack_i = 1'b0;
    logic              s_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wishbone_master_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .SEL_WIDTH      (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .m_wb_cyc_i (m_cyc),
        .m_wb_stb_i (m_stb),
        .m_wb_we_i  (m_we),
        .m_wb_sel_i (m_sel),
        .m_wb_adr_i (m_adr),
        .m_wb_dat_i (m_dat),
        .m_wb_dat_o (m_dat_o),
        .m_wb_ack_o (m_ack_o),
        .m_wb_err_o (m_err_o),
        .m_wb_gnt_o (m_gnt_o),
        .s_wb_cyc_o (s_cyc_o),
        .s_wb_stb_o (s_stb_o),
        .s_wb_we_o  (s_we_o),
        .s_wb_sel_o (s_sel_o),
        .s_wb_adr_o (s_adr_o),
        .s_wb_dat_o (s_dat_o),
        .s_wb_dat_i (s_dat_i),
        .s_wb_ack_i (s_ack_i),
        .s_wb_err_i (s_err_i)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
    endtask

    // Masters keep CYC for random stretches; the slave answers at random.
    task automatic applyStimulus();
        for (int i = 0; i < NM; i++) begin
            if (m_cyc[i]) begin
                if ($urandom_range(0, 5) == 0) m_cyc[i] = 1'b0;
            end else begin
                if ($urandom_range(0, 2) == 0) m_cyc[i] = 1'b1;
            end
            m_stb[i] = m_cyc[i] & ($urandom_range(0, 3) != 0);
            m_we[i]  = 1'($urandom);
        end
        m_sel   = NM*SW'($urandom);
        m_adr   = {$urandom, $urandom, $urandom};
        m_dat   = {$urandom, $urandom, $urandom};
        s_dat_i = $urandom;
        s_ack_i = ($urandom_range(0, 1) == 0);
        s_err_i = ($urandom_range(0, 9) == 0);
        rst     = ($urandom_range(0, 199) == 0);
    endtask

    // Behavioural model: current owner (-1 when idle), previous owner, stalled-cycle run.
    int owner = -1;
    int last_owner = NM - 1;
    int stall_run = 0;

    task automatic modelStep();
        logic          fire;
        logic [NM-1:0] exp_ack;
        logic [NM-1:0] exp_err;
        logic          own_cyc;
        logic          own_stb;
        fire    = 1'b0;
        own_cyc = (owner >= 0) ? 1'(m_cyc >> owner) : 1'b0;
        own_stb = (owner >= 0) ? 1'(m_stb >> owner) : 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        if (owner >= 0 && own_stb && !s_ack_i && !s_err_i && stall_run + 1 == TO) fire = 1'b1;
`endif
        exp_ack = (owner >= 0) ? (NM'(s_ack_i) << owner) : '0;
        exp_err = (owner >= 0) ? (NM'(s_err_i | fire) << owner) : '0;
        checkOutput("model_gnt", 64'(m_gnt_o), (owner >= 0) ? 64'(1) << owner : 64'(0));
        checkOutput("model_s_cyc", 64'(s_cyc_o), 64'(own_cyc));
        checkOutput("model_s_stb", 64'(s_stb_o), 64'(own_stb & ~fire));
        checkOutput("model_ack", 64'(m_ack_o), 64'(exp_ack));
        checkOutput("model_err", 64'(m_err_o), 64'(exp_err));
        checkOutput("model_dat_o", 64'(m_dat_o), 64'(s_dat_i));
        if (owner >= 0) begin
            checkOutput("model_s_we", 64'(s_we_o), 64'(1'(m_we >> owner)));
            checkOutput("model_s_sel", 64'(s_sel_o), 64'(m_sel[owner*SW +: SW]));
            checkOutput("model_s_adr", 64'(s_adr_o), 64'(m_adr[owner*AW +: AW]));
            checkOutput("model_s_dat", 64'(s_dat_o), 64'(m_dat[owner*DW +: DW]));
        end
        if (rst) begin
            owner      = -1;
            last_owner = NM - 1;
            stall_run  = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                int cand;
                cand = (last_owner + k) % NM;
                if (owner < 0 && 1'(m_cyc >> cand)) owner = cand;
            end
            stall_run = 0;
        end else if (!own_cyc) begin
            last_owner = owner;
            owner      = -1;
            stall_run  = 0;
        end else if (fire) begin
            stall_run = 0;
        end else if (own_stb && !s_ack_i && !s_err_i) begin
            stall_run++;
        end else begin
            stall_run = 0;
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            modelStep();
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int j_idx;
        int waited;
        int err_count;
        int first_err;
        logic stb_at_first;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("reset_gnt", 64'(m_gnt_o), 64'h0);
        checkOutput("reset_s_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("reset_ack", 64'(m_ack_o), 64'h0);

        // Single read by m0, slave acks with 0x1234
        tick();
        rst             = 1'b0;
        m_cyc[0]        = 1'b1;
        m_stb[0]        = 1'b1;
        m_we[0]         = 1'b0;
        m_adr[0 +: AW]  = 32'h0001_0004;
        s_ack_i         = 1'b1;
        s_dat_i         = 32'h1234;
        @(negedge clk);
        checkOutput("t1_latency_s_cyc", 64'(s_cyc_o), 64'h0);
        checkOutput("t1_latency_ack", 64'(m_ack_o), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("t1_gnt", 64'(m_gnt_o), 64'h1);
        checkOutput("t1_s_cyc", 64'(s_cyc_o), 64'h1);
        checkOutput("t1_s_adr", 64'(s_adr_o), 64'h0001_0004);
        checkOutput("t1_ack", 64'(m_ack_o), 64'h1);
        checkOutput("t1_m1_ack", 64'(m_ack_o[1]), 64'h0);
        checkOutput("t1_dat_o", 64'(m_dat_o), 64'h1234);
        tick();
        clearInputs();
        tick();
        tick();

        // Simultaneous request after reset, then handover through one IDLE cycle
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        m_cyc = 3'b011;
        m_stb = 3'b011;
        @(negedge clk);
        checkOutput("t2_pre_gnt", 64'(m_gnt_o), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("t2_first_gnt", 64'(m_gnt_o), 64'h1);
        tick();
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk);
        checkOutput("t2_hold_gnt", 64'(m_gnt_o), 64'h1);
        tick();
        @(negedge clk);
        checkOutput("t2_idle_gnt", 64'(m_gnt_o), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("t2_second_gnt", 64'(m_gnt_o), 64'h2);

        // m1 holds CYC over three acked writes while m0 waits
        tick();
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        m_we[1]  = 1'b1;
        s_ack_i  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checkOutput("t3_hold_gnt", 64'(m_gnt_o), 64'h2);
            checkOutput("t3_ack", 64'(m_ack_o), 64'h2);
            tick();
        end
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        s_ack_i  = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("t3_idle_gnt", 64'(m_gnt_o), 64'h0);
        tick();
        @(negedge clk);
        checkOutput("t3_m0_gnt", 64'(m_gnt_o), 64'h1);
        tick();
        clearInputs();
        tick();
        tick();

        // All three requesting continuously with short transfers
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        m_cyc   = 3'b111;
        m_stb   = 3'b111;
        s_ack_i = 1'b1;
        for (int j = 0; j < 6; j++) begin
            waited = 0;
            @(negedge clk);
            while (m_gnt_o == '0 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("t4_order", 64'(m_gnt_o), 64'(1) << (j % 3));
            j_idx = j % 3;
            for (int i = 0; i < NM; i++) if (m_gnt_o[i]) j_idx = i;
            tick();
            m_cyc[j_idx] = 1'b0;
            tick();
            m_cyc[j_idx] = 1'b1;
        end
        clearInputs();
        tick();
        tick();

        // Reset in the middle of an m0 transfer
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("t5_gnt_before", 64'(m_gnt_o), 64'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_s_cyc_before", 64'(s_cyc_o), 64'h1);
        tick();
        @(negedge clk);
        checkOutput("t5_s_cyc_after", 64'(s_cyc_o), 64'h0);
        checkOutput("t5_gnt_after", 64'(m_gnt_o), 64'h0);
        tick();
        rst = 1'b0;
        clearInputs();
        tick();
        tick();

        // Slave that never answers
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(posedge clk);
        err_count    = 0;
        first_err    = 0;
        stb_at_first = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (m_err_o[0]) begin
                err_count++;
                if (first_err == 0) begin
                    first_err    = k;
                    stb_at_first = s_stb_o;
                end
            end
        end
        checkOutput("t6_first_err_cycle", 64'(first_err), 64'd8);
        checkOutput("t6_stb_at_err", 64'(stb_at_first), 64'h0);
        checkOutput("t6_err_count", 64'(err_count), 64'd2);
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (m_err_o != '0) err_count++;
        end
        checkOutput("t6_no_err", 64'(err_count), 64'd0);
        checkOutput("t6_still_granted", 64'(m_gnt_o), 64'h1);
`endif
        tick();
        clearInputs();
        tick();
        tick();

        // Random traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
        end
        rst = 1'b0;
        clearInputs();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
